// File: rtl/hub75_scanner.sv
// HUB75 refresh engine: fetches top/bottom pixel pairs, shifts one bit-plane per pass,
// latches it and lights it for a binary-weighted time (BASE_TICKS << plane cycles).
module hub75_scanner #(
  parameter int COLS       = 64,
  parameter int ROW_BITS   = 4,
  parameter int PLANES     = 5,
  parameter int BASE_TICKS = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  output logic [ROW_BITS+$clog2(COLS)-1:0]  read_addr,
  output logic                              read_en,
  input  logic [15:0]                       read_data_top,
  input  logic [15:0]                       read_data_bottom,
  output logic [1:0]                        hub75_red,
  output logic [1:0]                        hub75_green,
  output logic [1:0]                        hub75_blue,
  output logic [ROW_BITS-1:0]               hub75_addr,
  output logic                              hub75_clk,
  output logic                              hub75_lat,
  output logic                              hub75_oe,
  output logic                              frame_start
);

  localparam int COL_W   = $clog2(COLS);
  localparam int PLANE_W = (PLANES > 1) ? $clog2(PLANES) : 1;
  localparam int TICK_W  = $clog2(BASE_TICKS << (PLANES - 1)) + 1;

  // IDLE only exists for the cycles reset is held; the first edge after release enters PRIME.
  typedef enum logic [2:0] {IDLE, PRIME, SHIFT, BLANK, LATCH, DISPLAY} state_t;

  state_t               state_q, state_d;
  logic                 phase_q, phase_d;
  logic [COL_W-1:0]     col_q, col_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [ROW_BITS-1:0]  row_q, row_d;
  logic [PLANE_W-1:0]   plane_q, plane_d;
  logic                 load_rgb, load_row;
  logic [TICK_W-1:0]    tick_last;

  logic [ROW_BITS+COL_W-1:0] read_addr_q;
  logic                      read_en_q, hub75_clk_q, hub75_lat_q, hub75_oe_q, frame_start_q;
  logic [1:0]                red_q, green_q, blue_q;
  logic [ROW_BITS-1:0]       hub75_addr_q;

  // RGB565 channels as 5-bit fields; green LSB (bit 5) is dropped.
  logic [4:0] top_r, top_g, top_b, bot_r, bot_g, bot_b;
  logic       unused_green_lsb;

  assign top_r = read_data_top[15:11];
  assign top_g = read_data_top[10:6];
  assign top_b = read_data_top[4:0];
  assign bot_r = read_data_bottom[15:11];
  assign bot_g = read_data_bottom[10:6];
  assign bot_b = read_data_bottom[4:0];
  assign unused_green_lsb = read_data_top[5] ^ read_data_bottom[5];

  assign tick_last = (TICK_W'(BASE_TICKS) << plane_q) - TICK_W'(1);

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    col_d    = col_q;
    tick_d   = tick_q;
    row_d    = row_q;
    plane_d  = plane_q;
    load_rgb = 1'b0;
    load_row = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = PRIME;
        phase_d = 1'b0;
      end
      PRIME: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d  = 1'b0;
          state_d  = SHIFT;
          col_d    = '0;
          load_rgb = 1'b1;
        end
      end
      SHIFT: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d  = 1'b0;
          load_rgb = 1'b1;
          if (col_q == COL_W'(COLS - 1)) begin
            state_d  = BLANK;
            load_row = 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      BLANK: state_d = LATCH;
      LATCH: begin
        state_d = DISPLAY;
        tick_d  = '0;
      end
      DISPLAY: begin
        if (tick_q == tick_last) begin
          state_d = PRIME;
          phase_d = 1'b0;
          if (plane_q == PLANE_W'(PLANES - 1)) begin
            plane_d = '0;
            row_d   = row_q + 1'b1;
          end else begin
            plane_d = plane_q + 1'b1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from next-state so the panel pins never glitch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      phase_q       <= 1'b0;
      col_q         <= '0;
      tick_q        <= '0;
      row_q         <= '0;
      plane_q       <= '0;
      read_addr_q   <= '0;
      read_en_q     <= 1'b0;
      hub75_clk_q   <= 1'b0;
      hub75_lat_q   <= 1'b0;
      hub75_oe_q    <= 1'b1;
      frame_start_q <= 1'b0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
      hub75_addr_q  <= '0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      col_q         <= col_d;
      tick_q        <= tick_d;
      row_q         <= row_d;
      plane_q       <= plane_d;
      read_addr_q   <= {row_d, (state_d == SHIFT) ? col_d + COL_W'(1) : COL_W'(0)};
      read_en_q     <= (state_d == PRIME) || (state_d == SHIFT);
      hub75_clk_q   <= (state_d == SHIFT) && phase_d;
      hub75_lat_q   <= (state_d == LATCH);
      hub75_oe_q    <= (state_d != DISPLAY);
      frame_start_q <= (state_d == PRIME) && !phase_d && (row_d == '0) && (plane_d == '0);
      if (load_rgb) begin
        red_q   <= {bot_r[plane_q], top_r[plane_q]};
        green_q <= {bot_g[plane_q], top_g[plane_q]};
        blue_q  <= {bot_b[plane_q], top_b[plane_q]};
      end
      if (load_row) begin
        hub75_addr_q <= row_q;
      end
    end
  end

  assign read_addr   = read_addr_q;
  assign read_en     = read_en_q;
  assign hub75_red   = red_q;
  assign hub75_green = green_q;
  assign hub75_blue  = blue_q;
  assign hub75_addr  = hub75_addr_q;
  assign hub75_clk   = hub75_clk_q;
  assign hub75_lat   = hub75_lat_q;
  assign hub75_oe    = hub75_oe_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_hub75_scanner.sv
// Scoreboard bench for hub75_scanner: stimulus queues expected lines, lit spans,
// addresses and frame intervals; a negedge monitor pops and compares them.
module tb_hub75_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  read_addr;
  logic        read_en;
  logic [15:0] read_data_top, read_data_bottom;
  logic [1:0]  hub75_red, hub75_green, hub75_blue;
  logic [3:0]  hub75_addr;
  logic        hub75_clk, hub75_lat, hub75_oe, frame_start;

  always #5 clk = ~clk;

  hub75_scanner dut (
    .clk              (clk),
    .reset            (reset),
    .read_addr        (read_addr),
    .read_en          (read_en),
    .read_data_top    (read_data_top),
    .read_data_bottom (read_data_bottom),
    .hub75_red        (hub75_red),
    .hub75_green      (hub75_green),
    .hub75_blue       (hub75_blue),
    .hub75_addr       (hub75_addr),
    .hub75_clk        (hub75_clk),
    .hub75_lat        (hub75_lat),
    .hub75_oe         (hub75_oe),
    .frame_start      (frame_start)
  );

  // RAM model, one-cycle read latency. Mode 0: top=col, bottom=col<<11.
  int mode = 0;
  always @(posedge clk) begin
    if (read_en) begin
      case (mode)
        0:       begin read_data_top <= {10'd0, read_addr[5:0]}; read_data_bottom <= {read_addr[4:0], 11'd0}; end
        1:       begin read_data_top <= 16'hF800; read_data_bottom <= 16'h001F; end
        default: begin read_data_top <= 16'h0840; read_data_bottom <= 16'h0000; end
      endcase
    end
  end

  typedef struct {
    int           row;
    logic [127:0] red;
    logic [127:0] green;
    logic [127:0] blue;
  } line_t;

  line_t exp_line[$];
  int    exp_span[$];
  int    exp_addr[$];
  int    exp_frame[$];

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  // Bit c set when bit p of column c is set.
  function automatic logic [63:0] colpat(input int p);
    case (p)
      0:       return 64'hAAAA_AAAA_AAAA_AAAA;
      1:       return 64'hCCCC_CCCC_CCCC_CCCC;
      2:       return 64'hF0F0_F0F0_F0F0_F0F0;
      3:       return 64'hFF00_FF00_FF00_FF00;
      default: return 64'hFFFF_0000_FFFF_0000;
    endcase
  endfunction

  // Channel vectors are {top bits, bottom bits}, bit c = value at clock rise c.
  task automatic push_line(input int row, input int p, input bit with_span);
    line_t l;
    l.row   = row;
    l.red   = '0;
    l.green = '0;
    l.blue  = '0;
    case (mode)
      0: begin l.red = {64'd0, colpat(p)}; l.blue = {colpat(p), 64'd0}; end
      1: begin l.red = {ONES, 64'd0}; l.blue = {64'd0, ONES}; end
      default: if (p == 0) begin l.red = {ONES, 64'd0}; l.green = {ONES, 64'd0}; end
    endcase
    exp_line.push_back(l);
    if (with_span) exp_span.push_back(16 << p);
  endtask

  // Sampled in PRIME cycles and SHIFT cycle A: {row,0},{row,0},{row,1}..{row,63},{row,0}.
  task automatic push_addr_rp(input int row);
    exp_addr.push_back(row * 64);
    exp_addr.push_back(row * 64);
    for (int c = 0; c < 64; c++) exp_addr.push_back(row * 64 + ((c + 1) % 64));
  endtask

  function automatic int pending();
    return exp_line.size() + exp_span.size() + exp_addr.size() + exp_frame.size();
  endfunction

  task automatic wait_drain(input int budget);
    int n = 0;
    while (pending() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("queues_drained", pending(), 0);
  endtask

  task automatic check_reset_vals();
    check("rst_oe", hub75_oe, 1);
    check("rst_read_en", read_en, 0);
    check("rst_lat", hub75_lat, 0);
    check("rst_clk", hub75_clk, 0);
    check("rst_rgb", {hub75_red, hub75_green, hub75_blue}, 0);
    check("rst_addr", hub75_addr, 0);
    check("rst_read_addr", read_addr, 0);
    check("rst_frame_start", frame_start, 0);
  endtask

  // Monitor
  initial begin
    int         rises = 0, span = 0, cyc = 0, last_fs = 0, e;
    bit         have_fs = 0, span_bad = 0;
    logic       prev_clk = 0;
    logic [3:0] span_addr = 0;
    logic [63:0] rt = 0, rb = 0, gt = 0, gb = 0, bt = 0, bb = 0;
    line_t      el;
    forever begin
      @(negedge clk);
      if (reset) begin
        rises = 0; span = 0; span_bad = 0; have_fs = 0; prev_clk = 0;
        rt = 0; rb = 0; gt = 0; gb = 0; bt = 0; bb = 0;
      end else begin
        cyc++;
        if (read_en && !hub75_clk && exp_addr.size() > 0) begin
          e = exp_addr.pop_front();
          check("read_addr", read_addr, e);
        end
        if (hub75_clk && !prev_clk) begin
          if (rises < 64) begin
            rt[rises] = hub75_red[0];   rb[rises] = hub75_red[1];
            gt[rises] = hub75_green[0]; gb[rises] = hub75_green[1];
            bt[rises] = hub75_blue[0];  bb[rises] = hub75_blue[1];
          end
          rises++;
        end
        if (hub75_lat) begin
          if (exp_line.size() > 0) begin
            el = exp_line.pop_front();
            check("line_row", hub75_addr, el.row);
            check("line_clk_rises", rises, 64);
            check("line_red", {rt, rb}, el.red);
            check("line_green", {gt, gb}, el.green);
            check("line_blue", {bt, bb}, el.blue);
          end
          rises = 0;
          rt = 0; rb = 0; gt = 0; gb = 0; bt = 0; bb = 0;
        end
        if (!hub75_oe) begin
          if (span == 0) span_addr = hub75_addr;
          else if (hub75_addr != span_addr) span_bad = 1;
          span++;
        end else if (span > 0) begin
          if (exp_span.size() > 0) begin
            e = exp_span.pop_front();
            check("oe_low_span", span, e);
            check("addr_stable_while_lit", span_bad, 0);
          end
          span = 0;
          span_bad = 0;
        end
        if (frame_start) begin
          if (have_fs && exp_frame.size() > 0) begin
            e = exp_frame.pop_front();
            check("frame_interval", cyc - last_fs, e);
          end
          have_fs = 1;
          last_fs = cyc;
        end
        prev_clk = hub75_clk;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    reset = 1'b1;
    mode  = 0;
    repeat (3) @(posedge clk);
    #1 check_reset_vals();

    push_addr_rp(0);
    push_addr_rp(0);
    for (int r = 0; r < 16; r++)
      for (int p = 0; p < 5; p++) push_line(r, p, 1);
    for (int r = 0; r < 7; r++)
      for (int p = 0; p < 5; p++) push_line(r, p, 1);
    for (int p = 0; p < 3; p++) push_line(7, p, 1);
    push_line(7, 3, 0);
    exp_frame.push_back(18496);

    reset = 1'b0;
    @(posedge clk);
    #1;
    check("first_frame_start", frame_start, 1);
    check("first_read_addr", read_addr, 0);
    check("first_read_en", read_en, 1);
    check("first_oe", hub75_oe, 1);

    // Frame 2, row 7, plane 3 is lit from offset 8732 for 128 cycles.
    repeat (18496 + 8782) @(posedge clk);
    #1;
    check("mid_display_oe", hub75_oe, 0);
    check("mid_display_row", hub75_addr, 7);
    check("queues_before_reset", pending(), 0);

    reset = 1'b1;
    @(posedge clk);
    #1 check_reset_vals();
    repeat (2) @(posedge clk);
    push_addr_rp(0);
    push_line(0, 0, 1);
    push_line(0, 1, 1);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    check("restart_frame_start", frame_start, 1);
    check("restart_read_addr", read_addr, 0);
    wait_drain(2000);

    for (int m = 1; m < 3; m++) begin
      reset = 1'b1;
      mode  = m;
      repeat (2) @(posedge clk);
      for (int p = 0; p < 5; p++) push_line(0, p, 1);
      #1 reset = 1'b0;
      wait_drain(3000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
